// File: rtl/store_size_handler_if.sv
// Store request / data-memory bundle for store_size_handler.
//   slave  : the store handler (receives the request and memory read data,
//            drives the memory address/write side and the status pulses).
//   master : the requester plus memory model on the other side.
// Signals:
//   start, size[1:0], addr[31:0], store_data[31:0]  request
//   mem_rdata[31:0]                                   memory read data
//   mem_addr[31:0], mem_wdata[31:0], mem_wr           memory access
//   busy, done, error                                 status
// Handshake: start is a level sampled only while the handler is idle (busy=0);
// a request is accepted on the rising edge where start=1 and busy=0, and
// exactly one of done/error pulses for one cycle when it completes.
interface store_size_handler_if;
  logic        start;
  logic [1:0]  size;
  logic [31:0] addr;
  logic [31:0] store_data;
  logic [31:0] mem_rdata;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_wr;
  logic        busy;
  logic        done;
  logic        error;

  modport slave (
    input  start, size, addr, store_data, mem_rdata,
    output mem_addr, mem_wdata, mem_wr, busy, done, error
  );

  modport master (
    output start, size, addr, store_data, mem_rdata,
    input  mem_addr, mem_wdata, mem_wr, busy, done, error
  );
endinterface

// File: rtl/store_size_handler.sv
// store_size_handler: performs SW/SH/SB on a 32-bit word-addressed memory.
// Word stores are written directly; halfword and byte stores read the
// target word, merge the new lane(s) in and write the whole word back.
// Misaligned or illegal-size requests pulse error without touching memory.
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous active-high reset
//   bus        store_size_handler_if.slave (request, memory, status)
//   dbg_state  current FSM state encoding (0 idle, 1 read, 2 capture,
//              3 write, 4 done, 5 err)
// Parameter MEM_LATENCY (1..7): cycles from mem_addr to valid mem_rdata.
module store_size_handler #(
  parameter int MEM_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  store_size_handler_if.slave   bus,
  output logic [2:0]            dbg_state
);

  typedef enum logic [2:0] {
    s_idle    = 3'd0,
    s_read    = 3'd1,
    s_capture = 3'd2,
    s_write   = 3'd3,
    s_done    = 3'd4,
    s_err     = 3'd5
  } state_t;

  localparam logic [1:0] size_word = 2'b00;
  localparam logic [1:0] size_half = 2'b01;
  localparam logic [1:0] size_byte = 2'b10;
  localparam logic [2:0] wait_last = 3'(MEM_LATENCY - 1);

  state_t      state_q, state_d;
  logic [31:0] addr_q;
  logic [1:0]  size_q;
  logic [15:0] data_q;   // only the low halfword is ever stored by sub-word ops
  logic [31:0] merge_q;
  logic [2:0]  wait_q;
  logic        accept;
  logic        legal;
  logic [31:0] merged;

  assign accept = (state_q == s_idle) && bus.start;

  // Legality is judged on the live inputs because it steers the accept edge.
  always_comb begin
    legal = 1'b0;
    case (bus.size)
      size_word: legal = (bus.addr[1:0] == 2'b00);
      size_half: legal = (bus.addr[0] == 1'b0);
      size_byte: legal = 1'b1;
      default:   legal = 1'b0;
    endcase
  end

  // Lane replacement on the word just read back from memory.
  always_comb begin
    merged = bus.mem_rdata;
    if (size_q == size_half) begin
      if (addr_q[1]) merged[31:16] = data_q;
      else           merged[15:0]  = data_q;
    end else if (size_q == size_byte) begin
      case (addr_q[1:0])
        2'd0:    merged[7:0]   = data_q[7:0];
        2'd1:    merged[15:8]  = data_q[7:0];
        2'd2:    merged[23:16] = data_q[7:0];
        default: merged[31:24] = data_q[7:0];
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= s_idle;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      s_idle: begin
        if (bus.start) begin
          if (!legal)                  state_d = s_err;
          else if (bus.size == size_word) state_d = s_write;
          else                         state_d = s_read;
        end
      end
      s_read:    if (wait_q == wait_last) state_d = s_capture;
      s_capture: state_d = s_write;
      s_write:   state_d = s_done;
      s_done:    state_d = s_idle;
      s_err:     state_d = s_idle;
      default:   state_d = s_idle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_q  <= '0;
      size_q  <= '0;
      data_q  <= '0;
      merge_q <= '0;
      wait_q  <= '0;
    end else if (accept) begin
      addr_q  <= bus.addr;
      size_q  <= bus.size;
      data_q  <= bus.store_data[15:0];
      // A word store writes straight from here; sub-word stores overwrite
      // this in CAPTURE.
      merge_q <= bus.store_data;
      wait_q  <= '0;
    end else if (state_q == s_read) begin
      wait_q  <= wait_q + 3'd1;
    end else if (state_q == s_capture) begin
      merge_q <= merged;
    end
  end

  // Every output is a decode of registered state, so reset clears them
  // without waiting for an edge.
  always_comb begin
    bus.busy      = (state_q != s_idle);
    bus.mem_wr    = (state_q == s_write);
    bus.done      = (state_q == s_done);
    bus.error     = (state_q == s_err);
    bus.mem_wdata = (state_q == s_write) ? merge_q : 32'd0;
    bus.mem_addr  = ((state_q == s_read) || (state_q == s_capture) ||
                     (state_q == s_write)) ? {addr_q[31:2], 2'b00} : 32'd0;
  end

  assign dbg_state = state_q;

endmodule

// File: tb/tb_store_size_handler.sv
module tb_store_size_handler;
  logic clk;
  logic reset;
  logic [2:0] dbg1, dbg3;
  int checks;
  int errors;

  logic [31:0] mem_arr [0:15];
  logic [31:0] p1;
  logic [31:0] p3 [0:2];

  store_size_handler_if bus1 ();
  store_size_handler_if bus3 ();

  store_size_handler #(.MEM_LATENCY(1)) dut1 (
    .clk(clk), .reset(reset), .bus(bus1.slave), .dbg_state(dbg1)
  );
  store_size_handler #(.MEM_LATENCY(3)) dut3 (
    .clk(clk), .reset(reset), .bus(bus3.slave), .dbg_state(dbg3)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // memory models: read data appears MEM_LATENCY cycles after the address
  always @(posedge clk) begin
    p1    <= mem_arr[bus1.mem_addr[5:2]];
    p3[0] <= mem_arr[bus3.mem_addr[5:2]];
    p3[1] <= p3[0];
    p3[2] <= p3[1];
  end
  assign bus1.mem_rdata = p1;
  assign bus3.mem_rdata = p3[2];

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic req1(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d);
    bus1.start = 1'b1; bus1.size = sz; bus1.addr = a; bus1.store_data = d;
  endtask

  task automatic test_reset();
    checks++;
    if ({bus1.mem_addr, bus1.mem_wdata, bus1.mem_wr, bus1.busy, bus1.done, bus1.error} !== 68'd0) begin
      errors++;
      $display("FAIL reset_outs1: got addr=%h wdata=%h wr=%b busy=%b done=%b err=%b required all 0",
               bus1.mem_addr, bus1.mem_wdata, bus1.mem_wr, bus1.busy, bus1.done, bus1.error);
    end
    checks++;
    if ({bus3.mem_addr, bus3.mem_wdata, bus3.mem_wr, bus3.busy, bus3.done, bus3.error} !== 68'd0) begin
      errors++;
      $display("FAIL reset_outs3: got busy=%b wr=%b required all 0", bus3.busy, bus3.mem_wr);
    end
    checks++;
    if (dbg1 !== 3'd0) begin errors++; $display("FAIL reset_state: got %0d required 0", dbg1); end
  endtask

  task automatic test_sw();
    req1(2'b00, 32'h10, 32'hDEADBEEF);
    step(); bus1.start = 1'b0;
    checks++;
    if ({bus1.mem_wr, bus1.done} !== 2'b10) begin
      errors++; $display("FAIL sw_c1_wr: got wr=%b done=%b required wr=1 done=0", bus1.mem_wr, bus1.done);
    end
    checks++;
    if (bus1.mem_addr !== 32'h10) begin
      errors++; $display("FAIL sw_addr: got %h required 00000010", bus1.mem_addr);
    end
    checks++;
    if (bus1.mem_wdata !== 32'hDEADBEEF) begin
      errors++; $display("FAIL sw_wdata: got %h required deadbeef", bus1.mem_wdata);
    end
    step();
    checks++;
    if ({bus1.done, bus1.mem_wr, bus1.busy, bus1.mem_wdata} !== {3'b101, 32'd0}) begin
      errors++; $display("FAIL sw_done: got done=%b wr=%b busy=%b wdata=%h required done=1 wr=0 busy=1 wdata=0",
                         bus1.done, bus1.mem_wr, bus1.busy, bus1.mem_wdata);
    end
    step();
    checks++;
    if ({bus1.busy, bus1.done, bus1.mem_addr} !== 34'd0) begin
      errors++; $display("FAIL sw_idle: got busy=%b done=%b addr=%h required 0", bus1.busy, bus1.done, bus1.mem_addr);
    end
  endtask

  task automatic test_sb_l1();
    req1(2'b10, 32'h13, 32'h000000AB);
    step(); bus1.start = 1'b0;
    checks++;
    if ({bus1.busy, bus1.mem_wr, bus1.mem_addr} !== {2'b10, 32'h10}) begin
      errors++; $display("FAIL sb_read: got busy=%b wr=%b addr=%h required busy=1 wr=0 addr=00000010",
                         bus1.busy, bus1.mem_wr, bus1.mem_addr);
    end
    step();
    checks++;
    if ({bus1.mem_wr, bus1.done, bus1.mem_addr} !== {2'b00, 32'h10}) begin
      errors++; $display("FAIL sb_capture: got wr=%b done=%b addr=%h required wr=0 done=0 addr=00000010",
                         bus1.mem_wr, bus1.done, bus1.mem_addr);
    end
    step();
    checks++;
    if ({bus1.mem_wr, bus1.mem_addr, bus1.mem_wdata} !== {1'b1, 32'h10, 32'hAB223344}) begin
      errors++; $display("FAIL sb_write: got wr=%b addr=%h wdata=%h required wr=1 addr=00000010 wdata=ab223344",
                         bus1.mem_wr, bus1.mem_addr, bus1.mem_wdata);
    end
    step();
    checks++;
    if ({bus1.done, bus1.mem_wr} !== 2'b10) begin
      errors++; $display("FAIL sb_done: got done=%b wr=%b required done=1 wr=0", bus1.done, bus1.mem_wr);
    end
    step();
  endtask

  task automatic test_sh_l3();
    bus3.start = 1'b1; bus3.size = 2'b01; bus3.addr = 32'h22; bus3.store_data = 32'h0000CAFE;
    step(); bus3.start = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      checks++;
      if ({bus3.busy, bus3.mem_wr, bus3.mem_addr} !== {2'b10, 32'h20}) begin
        errors++; $display("FAIL sh3_wait_c%0d: got busy=%b wr=%b addr=%h required busy=1 wr=0 addr=00000020",
                           c, bus3.busy, bus3.mem_wr, bus3.mem_addr);
      end
      step();
    end
    checks++;
    if ({bus3.mem_wr, bus3.mem_addr, bus3.mem_wdata} !== {1'b1, 32'h20, 32'hCAFE7788}) begin
      errors++; $display("FAIL sh3_write: got wr=%b addr=%h wdata=%h required wr=1 addr=00000020 wdata=cafe7788",
                         bus3.mem_wr, bus3.mem_addr, bus3.mem_wdata);
    end
    step();
    checks++;
    if ({bus3.done, bus3.mem_wr} !== 2'b10) begin
      errors++; $display("FAIL sh3_done: got done=%b wr=%b required done=1 wr=0", bus3.done, bus3.mem_wr);
    end
    step();
    checks++;
    if (bus3.busy !== 1'b0) begin errors++; $display("FAIL sh3_idle: got busy=%b required 0", bus3.busy); end
  endtask

  task automatic test_errors();
    logic [1:0]  e_size [3];
    logic [31:0] e_addr [3];
    e_size = '{2'b01, 2'b00, 2'b11};
    e_addr = '{32'h5, 32'h2, 32'h8};
    for (int i = 0; i < 3; i++) begin
      req1(e_size[i], e_addr[i], 32'h12345678);
      step(); bus1.start = 1'b0;
      checks++;
      if ({bus1.error, bus1.busy, bus1.mem_wr, bus1.done} !== 4'b1100) begin
        errors++; $display("FAIL err%0d_c1: got err=%b busy=%b wr=%b done=%b required err=1 busy=1 wr=0 done=0",
                           i, bus1.error, bus1.busy, bus1.mem_wr, bus1.done);
      end
      step();
      checks++;
      if ({bus1.error, bus1.busy, bus1.mem_wr, bus1.done} !== 4'b0000) begin
        errors++; $display("FAIL err%0d_c2: got err=%b busy=%b wr=%b done=%b required all 0",
                           i, bus1.error, bus1.busy, bus1.mem_wr, bus1.done);
      end
    end
  endtask

  task automatic test_lanes();
    logic [1:0]  t_size [5];
    logic [31:0] t_addr [5];
    logic [31:0] t_data [5];
    logic [31:0] t_exp  [5];
    t_size = '{2'b10, 2'b10, 2'b10, 2'b01, 2'b01};
    t_addr = '{32'h10, 32'h11, 32'h12, 32'h10, 32'h12};
    t_data = '{32'hFFFFFF5A, 32'h0000005A, 32'h0000005A, 32'hFFFF1234, 32'h00001234};
    t_exp  = '{32'h1122335A, 32'h11225A44, 32'h115A3344, 32'h11221234, 32'h12343344};
    for (int i = 0; i < 5; i++) begin
      req1(t_size[i], t_addr[i], t_data[i]);
      step(); bus1.start = 1'b0;
      step(); step();
      checks++;
      if ({bus1.mem_wr, bus1.mem_wdata} !== {1'b1, t_exp[i]}) begin
        errors++; $display("FAIL lane%0d: got wr=%b wdata=%h required wr=1 wdata=%h",
                           i, bus1.mem_wr, bus1.mem_wdata, t_exp[i]);
      end
      step(); step();
    end
  endtask

  task automatic test_back_to_back();
    req1(2'b10, 32'h13, 32'h000000AB);
    step();
    // start stays high; change the request mid-operation
    bus1.size = 2'b00; bus1.addr = 32'h30; bus1.store_data = 32'h12345678;
    step(); step();
    checks++;
    if ({bus1.mem_wr, bus1.mem_addr, bus1.mem_wdata} !== {1'b1, 32'h10, 32'hAB223344}) begin
      errors++; $display("FAIL b2b_first_write: got wr=%b addr=%h wdata=%h required wr=1 addr=00000010 wdata=ab223344",
                         bus1.mem_wr, bus1.mem_addr, bus1.mem_wdata);
    end
    step();
    checks++;
    if ({bus1.done, bus1.mem_wr} !== 2'b10) begin
      errors++; $display("FAIL b2b_first_done: got done=%b wr=%b required done=1 wr=0", bus1.done, bus1.mem_wr);
    end
    step();
    checks++;
    if (bus1.busy !== 1'b0) begin errors++; $display("FAIL b2b_idle_gap: got busy=%b required 0", bus1.busy); end
    step(); bus1.start = 1'b0;
    checks++;
    if ({bus1.mem_wr, bus1.mem_addr, bus1.mem_wdata} !== {1'b1, 32'h30, 32'h12345678}) begin
      errors++; $display("FAIL b2b_second_write: got wr=%b addr=%h wdata=%h required wr=1 addr=00000030 wdata=12345678",
                         bus1.mem_wr, bus1.mem_addr, bus1.mem_wdata);
    end
    step();
    checks++;
    if (bus1.done !== 1'b1) begin errors++; $display("FAIL b2b_second_done: got %b required 1", bus1.done); end
    step();
    checks++;
    if (bus1.busy !== 1'b0) begin errors++; $display("FAIL b2b_no_queue: got busy=%b required 0", bus1.busy); end
  endtask

  task automatic test_reset_mid();
    req1(2'b10, 32'h13, 32'h000000AB);
    step(); bus1.start = 1'b0;
    step(); step();
    checks++;
    if (bus1.mem_wr !== 1'b1) begin errors++; $display("FAIL rst_pre_write: got wr=%b required 1", bus1.mem_wr); end
    #1 reset = 1'b1;
    #1;
    checks++;
    if ({bus1.mem_addr, bus1.mem_wdata, bus1.mem_wr, bus1.busy, bus1.done, bus1.error} !== 68'd0) begin
      errors++; $display("FAIL rst_async_outs: got addr=%h wdata=%h wr=%b busy=%b done=%b err=%b required all 0",
                         bus1.mem_addr, bus1.mem_wdata, bus1.mem_wr, bus1.busy, bus1.done, bus1.error);
    end
    checks++;
    if (dbg1 !== 3'd0) begin errors++; $display("FAIL rst_async_state: got %0d required 0", dbg1); end
    step();
    reset = 1'b0;
    req1(2'b00, 32'h40, 32'hCAFEBABE);
    step(); bus1.start = 1'b0;
    checks++;
    if ({bus1.mem_wr, bus1.mem_addr, bus1.mem_wdata} !== {1'b1, 32'h40, 32'hCAFEBABE}) begin
      errors++; $display("FAIL rst_after_sw: got wr=%b addr=%h wdata=%h required wr=1 addr=00000040 wdata=cafebabe",
                         bus1.mem_wr, bus1.mem_addr, bus1.mem_wdata);
    end
    step();
    checks++;
    if (bus1.done !== 1'b1) begin errors++; $display("FAIL rst_after_done: got %b required 1", bus1.done); end
    step();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    for (int i = 0; i < 16; i++) mem_arr[i] = 32'd0;
    mem_arr[4] = 32'h11223344;
    mem_arr[8] = 32'h55667788;
    reset = 1'b1;
    bus1.start = 1'b0; bus1.size = 2'b00; bus1.addr = 32'd0; bus1.store_data = 32'd0;
    bus3.start = 1'b0; bus3.size = 2'b00; bus3.addr = 32'd0; bus3.store_data = 32'd0;
    step(); step();
    test_reset();
    reset = 1'b0;
    step();
    test_sw();
    test_sb_l1();
    test_sh_l3();
    test_errors();
    test_lanes();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
